inv_mix_columns_seq: RTL



---
 rtl/aes_pkg.sv | 39 +++
 rtl/MixColumnHelper.sv | 24 ++
 rtl/inv_mix_columns_seq.sv | 114 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers for the InvMixColumns engine.
package aes_pkg;

  localparam int unsigned AES_NB  = 4;
  localparam int unsigned COL_W   = 32;
  localparam int unsigned STATE_W = AES_NB * COL_W;

  typedef logic [STATE_W-1:0] state_t;
  typedef logic [COL_W-1:0]   col_t;
  typedef logic [1:0]         col_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } invmix_state_e;

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul9(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gmulb(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gmuld(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gmule(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/MixColumnHelper.sv
// Combinational inverse MixColumns of one 32-bit column (byte 0 = MSB).
module MixColumnHelper
  import aes_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  // Circulant matrix {0e,0b,0d,09}, one row rotation per output byte.
  always_comb begin
    col_out[31:24] = gmule(a0) ^ gmulb(a1) ^ gmuld(a2) ^ gmul9(a3);
    col_out[23:16] = gmul9(a0) ^ gmule(a1) ^ gmulb(a2) ^ gmuld(a3);
    col_out[15:8]  = gmuld(a0) ^ gmul9(a1) ^ gmule(a2) ^ gmulb(a3);
    col_out[7:0]   = gmulb(a0) ^ gmuld(a1) ^ gmul9(a2) ^ gmule(a3);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential InvMixColumns: one column per cycle through a shared helper.
// Optional feature macro INVMIX_BYPASS_EN adds in_bypass (copy state, latency 1).
module inv_mix_columns_seq
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
`ifdef INVMIX_BYPASS_EN
  ,
  input  logic         in_bypass
`endif
);

  localparam col_idx_t COL_LAST = col_idx_t'(AES_NB - 1);

  invmix_state_e state_q, state_d;
  col_idx_t      col_q, col_d;
  state_t        src_q, src_d;
  state_t        res_q, res_d;
  logic          out_valid_q;
  logic          accept;
  logic          bypass;
  col_t          helper_in;
  col_t          helper_out;

  // Ready whenever idle, or when the finished result leaves this cycle.
  assign in_ready  = (state_q == IDLE) || ((state_q == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_state = res_q;

`ifdef INVMIX_BYPASS_EN
  assign bypass = in_bypass;
`else
  assign bypass = 1'b0;
`endif

  // Select the source column addressed by the column counter.
  always_comb begin
    helper_in = src_q[127:96];
    case (col_q)
      2'd0: helper_in = src_q[127:96];
      2'd1: helper_in = src_q[95:64];
      2'd2: helper_in = src_q[63:32];
      2'd3: helper_in = src_q[31:0];
    endcase
  end

  MixColumnHelper u_helper (
    .col_in  (helper_in),
    .col_out (helper_out)
  );

  // Next-state, column sequencing and result-column writes.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    src_d   = src_q;
    res_d   = res_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          src_d = in_state;
          col_d = 2'd0;
          if (bypass) begin
            res_d   = in_state;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if ((state_q == DONE) && out_ready) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        case (col_q)
          2'd0: res_d[127:96] = helper_out;
          2'd1: res_d[95:64]  = helper_out;
          2'd2: res_d[63:32]  = helper_out;
          2'd3: res_d[31:0]   = helper_out;
        endcase
        col_d = col_q + 2'd1;
        if (col_q == COL_LAST) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      col_q       <= 2'd0;
      src_q       <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      src_q       <= src_d;
      res_q       <= res_d;
      out_valid_q <= (state_d == DONE);
    end
  end

endmodule
